// File: rtl/gpgpu_issue_pkg.sv
// Shared sizes, bundle field layout and helpers for the warp issue stage.
package gpgpu_issue_pkg;

  localparam int NUM_WARPS = 8;
  localparam int WID_W     = 3;
  localparam int INST_W    = 53;

  // Bundle field LSB offsets and widths (bit 0 is the LSB of Active_Mask).
  localparam int ACTIVE_MASK_LSB = 0;
  localparam int ACTIVE_MASK_W   = 8;
  localparam int BLT_LSB         = 8;
  localparam int BEQ_LSB         = 9;
  localparam int IMME_VALID_LSB  = 10;
  localparam int SHARE_GB_LSB    = 11;
  localparam int ALU_OPCODE_LSB  = 12;
  localparam int ALU_OPCODE_W    = 4;
  localparam int MEM_READ_LSB    = 16;
  localparam int MEM_WRITE_LSB   = 17;
  localparam int REG_WRITE_LSB   = 18;
  localparam int IMME_ADDR_LSB   = 19;
  localparam int IMME_ADDR_W     = 16;
  localparam int DST_LSB         = 35;
  localparam int SRC2_LSB        = 41;
  localparam int SRC1_LSB        = 47;
  localparam int REG_ADDR_W      = 6;

  function automatic logic is_branch(input logic [INST_W-1:0] bundle);
    return bundle[BEQ_LSB] | bundle[BLT_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at ptr and wraps upward.
module rr_arbiter #(
  parameter int N = 8,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_issue_unit.sv
// Issue stage: round-robin pick of a ready warp, one-entry output register,
// and per-warp blocking after a branch until the branch unit resolves it.
module warp_issue_unit
  import gpgpu_issue_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WARPS-1:0]        IB_Ready_Issue_IU,
  input  logic [NUM_WARPS*INST_W-1:0] IB_Inst_In,
  output logic [NUM_WARPS-1:0]        IU_Grant,
  input  logic                        OC_Ready,
  input  logic                        Br_Resolve_Valid,
  input  logic [WID_W-1:0]            Br_Resolve_Warp_ID,
  output logic                        Issue_Valid_OC,
  output logic [WID_W-1:0]            Issue_Warp_ID_OC,
  output logic [INST_W-1:0]           Issue_Inst_OC,
  output logic [NUM_WARPS-1:0]        Branch_Pending
);

  // Handshake toward the operand collector: the held bundle transfers on any
  // cycle with Issue_Valid_OC & OC_Ready; while valid and not ready, all
  // Issue_*_OC fields stay frozen and no new grant is given.

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] arb_req;
  logic [NUM_WARPS-1:0] gnt;
  logic [NUM_WARPS-1:0] branch_pending_q;
  logic [NUM_WARPS-1:0] branch_pending_d;
  logic                 can_load;
  logic                 grant_any;
  logic [WID_W-1:0]     rr_ptr;
  logic [WID_W-1:0]     grant_id;
  logic [INST_W-1:0]    inst_arr [NUM_WARPS];
  logic [INST_W-1:0]    grant_inst;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_slice
    assign inst_arr[w] = IB_Inst_In[w*INST_W +: INST_W];
  end

  assign eligible  = IB_Ready_Issue_IU & ~branch_pending_q;
  assign can_load  = !Issue_Valid_OC || OC_Ready;
  // Gating with rst_n keeps buffers from popping while the stage is held in reset.
  assign arb_req   = (can_load && rst_n) ? eligible : '0;
  assign grant_any = |gnt;
  assign IU_Grant  = gnt;
  assign Branch_Pending = branch_pending_q;

  rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (gnt[i]) grant_id = WID_W'(i);
    end
  end

  assign grant_inst = inst_arr[grant_id];

  // Resolve is applied after the set so it wins a forced same-warp conflict.
  always_comb begin
    branch_pending_d = branch_pending_q;
    if (grant_any && is_branch(grant_inst)) branch_pending_d[grant_id] = 1'b1;
    if (Br_Resolve_Valid) branch_pending_d[Br_Resolve_Warp_ID] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      branch_pending_q <= '0;
      Issue_Valid_OC   <= 1'b0;
      Issue_Warp_ID_OC <= '0;
      Issue_Inst_OC    <= '0;
    end else begin
      branch_pending_q <= branch_pending_d;
      if (grant_any) begin
        rr_ptr           <= (grant_id == WID_W'(NUM_WARPS-1)) ? '0 : grant_id + 1'b1;
        Issue_Valid_OC   <= 1'b1;
        Issue_Warp_ID_OC <= grant_id;
        Issue_Inst_OC    <= grant_inst;
      end else if (OC_Ready) begin
        Issue_Valid_OC   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_warp_issue_unit.sv
// Bench for warp_issue_unit: directed vector table, hand sequences for reset,
// and randomized traffic against a queue-based reference model.
module tb_warp_issue_unit;
  import gpgpu_issue_pkg::*;

  localparam int QW = WID_W + INST_W;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_WARPS-1:0]        IB_Ready_Issue_IU;
  logic [NUM_WARPS*INST_W-1:0] IB_Inst_In;
  logic [NUM_WARPS-1:0]        IU_Grant;
  logic                        OC_Ready;
  logic                        Br_Resolve_Valid;
  logic [WID_W-1:0]            Br_Resolve_Warp_ID;
  logic                        Issue_Valid_OC;
  logic [WID_W-1:0]            Issue_Warp_ID_OC;
  logic [INST_W-1:0]           Issue_Inst_OC;
  logic [NUM_WARPS-1:0]        Branch_Pending;

  warp_issue_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .IB_Ready_Issue_IU  (IB_Ready_Issue_IU),
    .IB_Inst_In         (IB_Inst_In),
    .IU_Grant           (IU_Grant),
    .OC_Ready           (OC_Ready),
    .Br_Resolve_Valid   (Br_Resolve_Valid),
    .Br_Resolve_Warp_ID (Br_Resolve_Warp_ID),
    .Issue_Valid_OC     (Issue_Valid_OC),
    .Issue_Warp_ID_OC   (Issue_Warp_ID_OC),
    .Issue_Inst_OC      (Issue_Inst_OC),
    .Branch_Pending     (Branch_Pending)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];     // models the one-entry output register
  bit   m_bp [NUM_WARPS];      // modelled branch-pending flags
  int   m_ptr;                 // modelled round-robin start warp

  typedef struct {
    logic [7:0] req;
    logic [7:0] br;
    logic       oc;
    logic       rv;
    logic [2:0] rwid;
    logic [7:0] exp_gnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 0;
    for (int w = 0; w < NUM_WARPS; w++) m_bp[w] = 0;
  endtask

  function automatic logic [7:0] model_bp_vec();
    logic [7:0] v;
    for (int w = 0; w < NUM_WARPS; w++) v[w] = m_bp[w];
    return v;
  endfunction

  // First eligible warp scanning upward from m_ptr, or -1 when nothing can issue.
  function automatic int model_pick(input logic [7:0] req, input logic oc);
    if (exp_q.size() != 0 && !oc) return -1;
    for (int k = 0; k < NUM_WARPS; k++) begin
      int w;
      w = (m_ptr + k) % NUM_WARPS;
      if (req[w] && !m_bp[w]) return w;
    end
    return -1;
  endfunction

  function automatic vec_t mk(input logic [7:0] req, input logic [7:0] br, input logic oc,
                              input logic rv, input logic [2:0] rwid, input logic [7:0] eg);
    vec_t v;
    v.req = req; v.br = br; v.oc = oc; v.rv = rv; v.rwid = rwid; v.exp_gnt = eg;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_bus(input logic [7:0] br);
    for (int w = 0; w < NUM_WARPS; w++) begin
      logic [63:0] r;
      logic [INST_W-1:0] s;
      r = {$urandom, $urandom};
      s = r[INST_W-1:0];
      s[BEQ_LSB] = 1'b0;
      s[BLT_LSB] = 1'b0;
      if (br[w]) begin
        if ($urandom_range(0, 1) == 0) s[BEQ_LSB] = 1'b1;
        else                           s[BLT_LSB] = 1'b1;
      end
      IB_Inst_In[w*INST_W +: INST_W] = s;
    end
  endtask

  // One clock: drive, check at negedge, advance model at the posedge.
  task automatic step(input logic [7:0] req, input logic [7:0] br, input logic oc,
                      input logic rv, input logic [2:0] rwid,
                      input logic use_exp, input logic [7:0] exp_gnt);
    int gw;
    logic [7:0] mg;
    IB_Ready_Issue_IU  = req;
    OC_Ready           = oc;
    Br_Resolve_Valid   = rv;
    Br_Resolve_Warp_ID = rwid;
    drive_bus(br);
    @(negedge clk);
    gw = model_pick(req, oc);
    mg = '0;
    if (gw >= 0) mg[gw] = 1'b1;
    chk("grant_model", IU_Grant, mg);
    if (use_exp) chk("grant_table", IU_Grant, exp_gnt);
    chk("branch_pending", Branch_Pending, model_bp_vec());
    if (exp_q.size() != 0) begin
      chk("issue_valid", Issue_Valid_OC, 1'b1);
      chk("issue_payload", {Issue_Warp_ID_OC, Issue_Inst_OC}, exp_q[0]);
    end else begin
      chk("issue_valid", Issue_Valid_OC, 1'b0);
    end
    @(posedge clk);
    if (exp_q.size() != 0 && oc) void'(exp_q.pop_front());
    if (gw >= 0) begin
      logic [INST_W-1:0] s;
      s = IB_Inst_In[gw*INST_W +: INST_W];
      exp_q.push_back({WID_W'(gw), s});
      m_ptr = (gw + 1) % NUM_WARPS;
      if (s[BEQ_LSB] || s[BLT_LSB]) m_bp[gw] = 1;
    end
    if (rv) m_bp[rwid] = 0;
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    IB_Ready_Issue_IU = '0;
    IB_Inst_In = '0;
    OC_Ready = 1'b0;
    Br_Resolve_Valid = 1'b0;
    Br_Resolve_Warp_ID = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", Issue_Valid_OC, 1'b0);
    chk("rst_wid", Issue_Warp_ID_OC, 3'd0);
    chk("rst_inst", Issue_Inst_OC, '0);
    chk("rst_bp", Branch_Pending, 8'h00);
    chk("rst_grant", IU_Grant, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All warps requesting: 0..7 then wrap to 0.
    for (int i = 0; i < 9; i++) tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 8'(1 << (i % 8))));
    // Warps 2 and 5 with the pointer moved to 6 by the first grant.
    tbl.push_back(mk(8'h20, 8'h00, 1'b1, 1'b0, 3'd0, 8'h20));
    tbl.push_back(mk(8'h24, 8'h00, 1'b1, 1'b0, 3'd0, 8'h04));
    tbl.push_back(mk(8'h24, 8'h00, 1'b1, 1'b0, 3'd0, 8'h20));
    tbl.push_back(mk(8'h24, 8'h00, 1'b1, 1'b0, 3'd0, 8'h04));
    // Backpressure for 3 cycles, then warp 1 loads.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h02, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00));
    tbl.push_back(mk(8'h02, 8'h00, 1'b1, 1'b0, 3'd0, 8'h02));
    tbl.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00));
    // Warp 3 branch, resolved 5 cycles later; warp 6 still issues meanwhile.
    tbl.push_back(mk(8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 8'h08));
    tbl.push_back(mk(8'h48, 8'h00, 1'b1, 1'b0, 3'd0, 8'h40));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h08, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00));
    tbl.push_back(mk(8'h08, 8'h00, 1'b1, 1'b1, 3'd3, 8'h00));
    tbl.push_back(mk(8'h08, 8'h00, 1'b1, 1'b0, 3'd0, 8'h08));
    // Resolve of non-pending warp 4 while warp 4 issues a non-branch.
    tbl.push_back(mk(8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 8'h10));
    // Build Branch_Pending = 8'h81 and hold a valid instruction.
    tbl.push_back(mk(8'h81, 8'h81, 1'b1, 1'b0, 3'd0, 8'h80));
    tbl.push_back(mk(8'h81, 8'h81, 1'b1, 1'b0, 3'd0, 8'h01));
    tbl.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00));

    foreach (tbl[i]) step(tbl[i].req, tbl[i].br, tbl[i].oc, tbl[i].rv, tbl[i].rwid, 1'b1, tbl[i].exp_gnt);

    // Asynchronous reset while a transfer is held.
    chk("pre_rst_bp", Branch_Pending, 8'h81);
    chk("pre_rst_valid", Issue_Valid_OC, 1'b1);
    IB_Ready_Issue_IU = 8'hFF;
    OC_Ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", Issue_Valid_OC, 1'b0);
    chk("mid_rst_wid", Issue_Warp_ID_OC, 3'd0);
    chk("mid_rst_inst", Issue_Inst_OC, '0);
    chk("mid_rst_bp", Branch_Pending, 8'h00);
    @(negedge clk);
    chk("mid_rst_grant", IU_Grant, 8'h00);
    @(posedge clk);
    @(negedge clk);
    IB_Ready_Issue_IU = 8'h00;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step(8'h24, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h04);
    step(8'h24, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h20);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] req, br;
      logic oc, rv;
      logic [2:0] rwid;
      req = 8'($urandom_range(0, 255));
      br = '0;
      for (int w = 0; w < NUM_WARPS; w++) br[w] = ($urandom_range(0, 5) == 0);
      oc = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      rwid = 3'($urandom_range(0, 7));
      if (rv && $urandom_range(0, 1) == 1) begin
        for (int w = 0; w < NUM_WARPS; w++) if (m_bp[(int'(rwid) + w) % NUM_WARPS]) begin
          rwid = 3'((int'(rwid) + w) % NUM_WARPS);
          break;
        end
      end
      step(req, br, oc, rv, rwid, 1'b0, 8'h00);
    end

    // Drain.
    for (int n = 0; n < 3; n++) step(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
